// File: rtl/conv_window_gen_pkg.sv
// Shared types and sizing constants for the 3x3 convolution window generator.
package conv_window_gen_pkg;
  localparam int WID_LINE_DEF = 16;
  localparam int MAX_WIDTH_DEF = 256;
  localparam int CNT_W = $clog2(MAX_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel storage: single address, combinational read, synchronous write.
// Contents are deliberately not reset; stale entries are never part of an emitted window.
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int WID   = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic [AW-1:0]  addr,
  input  logic           wr_en,
  input  logic [WID-1:0] wr_data,
  output logic [WID-1:0] rd_data
);
  logic [WID-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];
endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster pixel stream into 3x3 "valid" convolution windows for the MAC array.
// state | meaning
// IDLE  | waiting for start; bad config pulses cfg_err
// RUN   | accepting pixels, emitting windows through one output register stage
// FLUSH | last pixel taken; waiting for the final window to handshake
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int WID_LINE  = WID_LINE_DEF,
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int WID_DIM   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WID_DIM-1:0]         cfg_width,
  input  logic [WID_DIM-1:0]         cfg_height,
  output logic                       cfg_err,
  input  logic signed [WID_LINE-1:0] in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [WID_LINE-1:0] win_1,
  output logic signed [WID_LINE-1:0] win_2,
  output logic signed [WID_LINE-1:0] win_3,
  output logic signed [WID_LINE-1:0] win_4,
  output logic signed [WID_LINE-1:0] win_5,
  output logic signed [WID_LINE-1:0] win_6,
  output logic signed [WID_LINE-1:0] win_7,
  output logic signed [WID_LINE-1:0] win_8,
  output logic signed [WID_LINE-1:0] win_9,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       done
);
  localparam int COL_W = $clog2(MAX_WIDTH);

  state_t state, state_nxt;
  logic [COL_W-1:0]   col, col_last;
  logic [WID_DIM-1:0] row, row_last;
  logic signed [WID_LINE-1:0] win [9];
  logic [WID_LINE-1:0] lb0_rd, lb1_rd;
  logic accept, last_pix, cfg_ok, load, cfg_err_nxt, done_nxt;

  assign cfg_ok = (cfg_width >= WID_DIM'(3)) && (cfg_width <= WID_DIM'(MAX_WIDTH))
                  && (cfg_height >= WID_DIM'(3));
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_pix = (row == row_last) && (col == col_last);

  line_buffer #(.DEPTH(MAX_WIDTH), .WID(WID_LINE)) lb0 (
    .clk(clk), .addr(col), .wr_en(accept), .wr_data(in_pixel), .rd_data(lb0_rd)
  );
  line_buffer #(.DEPTH(MAX_WIDTH), .WID(WID_LINE)) lb1 (
    .clk(clk), .addr(col), .wr_en(accept), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    cfg_err_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_nxt = RUN;
            load      = 1'b1;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      RUN:   if (accept && last_pix) state_nxt = FLUSH;
      FLUSH: begin
        if (out_valid && out_ready && out_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cfg_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= cfg_err_nxt;
      done    <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      col_last  <= '0;
      row_last  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      col_last <= COL_W'(cfg_width - WID_DIM'(1));
      row_last <= cfg_height - WID_DIM'(1);
    end else if (accept) begin
      // Oldest column falls off the left; the new column {row-2, row-1, row} enters on the right.
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_rd;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_rd;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_pixel;
      out_valid <= (row >= WID_DIM'(2)) && (col >= COL_W'(2));
      out_last  <= last_pix;
      if (col == col_last) begin
        col <= '0;
        row <= row + WID_DIM'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign win_1 = win[0];
  assign win_2 = win[1];
  assign win_3 = win[2];
  assign win_4 = win[3];
  assign win_5 = win[4];
  assign win_6 = win[5];
  assign win_7 = win[6];
  assign win_8 = win[7];
  assign win_9 = win[8];
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: frames of several shapes, backpressure, bad config,
// mid-frame reset and an ignored restart; windows are checked against a pixel-index model.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  localparam int WL = WID_LINE_DEF;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [WD-1:0] cfg_width = '0, cfg_height = '0;
  logic cfg_err, in_ready, out_valid, out_last, done;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [WL-1:0] in_pixel = '0;
  logic signed [WL-1:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;

  int n_chk = 0;
  int n_bad = 0;

  conv_window_gen dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_err(cfg_err), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4), .win_5(win_5),
    .win_6(win_6), .win_7(win_7), .win_8(win_8), .win_9(win_9),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0: row*16+col, 1: col-128, 2: raster index + 1
  function automatic int pix(input int pmode, input int idx, input int w);
    case (pmode)
      0:       return (idx / w) * 16 + (idx % w);
      1:       return (idx % w) - 128;
      default: return idx + 1;
    endcase
  endfunction

  function automatic bit rdy(input int rmode, input int cyc);
    return (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
  endfunction

  task automatic run_frame(input int w, input int h, input int pmode, input int rmode,
                           input int abort_n, input int restart_at,
                           output int f1, output int f5, output int l1, output int l9);
    int idx = 0, cyc = 0, nwin = 0, ndone = 0, tail = -1, total;
    bit fin = 1'b0, acc;
    int wv[9];
    total = (w - 2) * (h - 2);
    f1 = 0; f5 = 0; l1 = 0; l9 = 0;
    cfg_width  = WD'(w);
    cfg_height = WD'(h);
    in_pixel   = WL'(pix(pmode, 0, w));
    in_valid   = 1'b1;
    out_ready  = rdy(rmode, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) chk_val("hold_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        wv = '{int'(win_1), int'(win_2), int'(win_3), int'(win_4), int'(win_5),
               int'(win_6), int'(win_7), int'(win_8), int'(win_9)};
        for (int k = 0; k < 9; k++) begin
          int r, c;
          r = nwin / (w - 2) + k / 3;
          c = nwin % (w - 2) + k % 3;
          chk_val($sformatf("win%0d_%0d", nwin, k + 1), wv[k], pix(pmode, r * w + c, w));
        end
        chk_val($sformatf("last%0d", nwin), int'(out_last), int'(nwin == total - 1));
        if (nwin == 0) begin f1 = wv[0]; f5 = wv[4]; end
        l1 = wv[0]; l9 = wv[8];
        nwin++;
      end
      if (done) ndone++;
      if (done && tail < 0) tail = 3;
      else if (tail > 0) tail--;
      fin = (tail == 0);
      @(posedge clk); #1;
      if (acc) idx++;
      if (abort_n > 0 && idx == abort_n) begin
        in_valid = 1'b0;
        return;
      end
      if (idx >= w * h) in_valid = 1'b0;
      in_pixel = WL'(pix(pmode, idx, w));
      cyc++;
      out_ready = rdy(rmode, cyc);
      if (cyc == restart_at) begin
        start = 1'b1;
        cfg_width = WD'(5);
      end else begin
        start = 1'b0;
      end
    end
    chk_val("frame_finished", int'(fin), 1);
    chk_val("window_count", nwin, total);
    chk_val("done_pulses", ndone, 1);
    chk_val("idle_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
  endtask

  task automatic bad_cfg(input int w, input int h);
    cfg_width  = WD'(w);
    cfg_height = WD'(h);
    start = 1'b1;
    @(negedge clk);
    chk_val("cfg_err_early", int'(cfg_err), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_val($sformatf("cfg_err_w%0d_h%0d", w, h), int'(cfg_err), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_val("bad_in_ready", int'(in_ready), 0);
      chk_val("bad_out_valid", int'(out_valid), 0);
      chk_val("bad_cfg_err_once", int'(cfg_err), 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int f1, f5, l1, l9;
    repeat (3) @(negedge clk);
    chk_val("rst_in_ready", int'(in_ready), 0);
    chk_val("rst_out_valid", int'(out_valid), 0);
    chk_val("rst_out_last", int'(out_last), 0);
    chk_val("rst_done", int'(done), 0);
    chk_val("rst_cfg_err", int'(cfg_err), 0);
    chk_val("rst_win_1", int'(win_1), 0);
    chk_val("rst_win_9", int'(win_9), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(4, 4, 0, 0, 0, 0, f1, f5, l1, l9);
    chk_val("t1_first_w1", f1, 0);
    chk_val("t1_first_w5", f5, 17);
    chk_val("t1_last_w1", l1, 17);
    chk_val("t1_last_w9", l9, 51);

    run_frame(4, 4, 0, 1, 0, 0, f1, f5, l1, l9);
    chk_val("t2_first_w1", f1, 0);
    chk_val("t2_last_w9", l9, 51);

    bad_cfg(2, 4);
    bad_cfg(257, 3);
    bad_cfg(4, 2);

    run_frame(256, 3, 1, 0, 0, 0, f1, f5, l1, l9);
    chk_val("t4_first_w1", f1, -128);
    chk_val("t4_first_w5", f5, -127);
    chk_val("t4_last_w1", l1, 125);
    chk_val("t4_last_w9", l9, 127);

    run_frame(4, 4, 0, 0, 10, 0, f1, f5, l1, l9);
    rst = 1'b1;
    #2;
    chk_val("mid_rst_in_ready", int'(in_ready), 0);
    chk_val("mid_rst_out_valid", int'(out_valid), 0);
    chk_val("mid_rst_out_last", int'(out_last), 0);
    chk_val("mid_rst_done", int'(done), 0);
    chk_val("mid_rst_win_5", int'(win_5), 0);
    chk_val("mid_rst_win_9", int'(win_9), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(3, 3, 2, 0, 0, 0, f1, f5, l1, l9);
    chk_val("t5_w1", f1, 1);
    chk_val("t5_w5", f5, 5);
    chk_val("t5_w9", l9, 9);

    run_frame(4, 4, 0, 0, 0, 5, f1, f5, l1, l9);
    chk_val("t6_first_w1", f1, 0);
    chk_val("t6_last_w9", l9, 51);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
